// File: rtl/bcd_counter_pkg.sv
// Shared constants and digit type for the two-digit BCD counter.
package bcd_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic logic bcd_is_max(input bcd_t v);
    return v == BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counting mod 10 with enable; codes 10-15 reload to 0 on the next enabled edge.
module bcd_digit
  import bcd_counter_pkg::*;
#(
  parameter bit SATURATE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output bcd_t q,
  output logic tc
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      if (q_q > BCD_MAX) begin
        q_d = BCD_ZERO;
      end else if (bcd_is_max(q_q)) begin
        q_d = SATURATE ? BCD_MAX : BCD_ZERO;
      end else begin
        q_d = q_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  always_comb begin
    q  = q_q;
    tc = bcd_is_max(q_q) & en;
  end

endmodule

// File: rtl/bcd_counter_100.sv
// Two-digit BCD counter 00-99 with carry. Define BCD_COUNTER_100_SATURATE_EN to
// saturate at 99 and turn c into a level "full" flag.
module bcd_counter_100
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic       c
);

`ifdef BCD_COUNTER_100_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic units_en;
  logic units_tc;
  logic tens_tc;
  logic full;
  bcd_t units_q;
  bcd_t tens_q;

  bcd_digit #(.SATURATE(1'b0)) units (
    .clk   (clk),
    .reset (reset),
    .en    (units_en),
    .q     (units_q),
    .tc    (units_tc)
  );

  bcd_digit #(.SATURATE(SAT)) tens (
    .clk   (clk),
    .reset (reset),
    .en    (units_tc),
    .q     (tens_q),
    .tc    (tens_tc)
  );

  always_comb begin
    full = bcd_is_max(units_q) & bcd_is_max(tens_q);
    q0   = units_q;
    q1   = tens_q;
`ifdef BCD_COUNTER_100_SATURATE_EN
    // Gating the units enable at 99 freezes both digits; tens_tc is then always 0 at 99.
    units_en = d & ~full;
    c        = full | tens_tc;
`else
    units_en = d;
    c        = tens_tc;
`endif
  end

endmodule

// File: tb/tb_bcd_counter_100.sv
// Self-checking bench for bcd_counter_100: directed scenarios plus random enable/reset
// traffic against an integer count model (handles both builds).
module tb_bcd_counter_100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       d = 1'b0;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       c;

  int n_cmp = 0;
  int n_err = 0;
  int count = 0;
  bit known = 1'b0;

  bcd_counter_100 dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q0    (q0),
    .q1    (q1),
    .c     (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (model count %0d)", tag, obs, exp, count);
    end
  endtask

`ifdef BCD_COUNTER_100_SATURATE_EN
  function automatic int model_c(input int cnt, input bit en);
    return (cnt == 99) ? 1 : 0;
  endfunction
  function automatic int model_next(input int cnt);
    return (cnt >= 99) ? 99 : cnt + 1;
  endfunction
`else
  function automatic int model_c(input int cnt, input bit en);
    return (cnt == 99 && en) ? 1 : 0;
  endfunction
  function automatic int model_next(input int cnt);
    return (cnt + 1) % 100;
  endfunction
`endif

  // Inputs are applied 1 time unit after a rising edge; c is checked before the
  // next edge, the digits 1 time unit after it.
  task automatic step(input bit r, input bit en, input string tag);
    reset = r;
    d     = en;
    #2;
    if (known) check({tag, ".c"}, int'(c), model_c(count, en));
    @(posedge clk);
    if (r) begin
      count = 0;
      known = 1'b1;
    end else if (en && known) begin
      count = model_next(count);
    end
    #1;
    if (known) begin
      check({tag, ".q1"}, int'(q1), count / 10);
      check({tag, ".q0"}, int'(q0), count % 10);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, "reset");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, "idle");
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, "count18");
    check("at18.q1", int'(q1), 1);
    check("at18.q0", int'(q0), 8);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, "hold");

    step(1'b1, 1'b0, "reset2");
    for (int i = 0; i < 99; i++) step(1'b0, 1'b1, "to99");
    check("at99.q1", int'(q1), 9);
    check("at99.q0", int'(q0), 9);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold99");
    step(1'b0, 1'b1, "edge100");
`ifndef BCD_COUNTER_100_SATURATE_EN
    check("wrap.q0", int'(q0), 0);
    check("wrap.q1", int'(q1), 0);
`endif

    step(1'b1, 1'b0, "reset3");
    for (int i = 0; i < 47; i++) step(1'b0, 1'b1, "to47");
    check("at47.q1", int'(q1), 4);
    step(1'b1, 1'b1, "reset47");
    check("after_rst.q0", int'(q0), 0);
    step(1'b0, 1'b1, "resume");
    check("resume.q0", int'(q0), 1);

    step(1'b1, 1'b0, "reset4");
    for (int i = 0; i < 105; i++) step(1'b0, 1'b1, "run105");
    step(1'b1, 1'b1, "reset5");

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_counter_100.md
# bcd_counter_100

Two-digit BCD counter that counts 00 to 99 while its count-enable input is high. It wraps to 00 and flags the wrap with a carry output. It is a leaf timing/event counter intended for chaining: the carry of one instance drives the enable of the next for counts beyond 99. Both digits are exposed directly for 7-segment or BCD display logic.

## Interface
- No parameters; digit width (4) and modulus (100) are fixed constants.
- `clk`: input, 1 bit. Sole clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset; clears all state on the next rising edge.
- `d`: input, 1 bit. Count enable, sampled on the rising edge.
- `q0`: output, 4 bits. Units digit, BCD 0–9, registered.
- `q1`: output, 4 bits. Tens digit, BCD 0–9, registered.
- `c`: output, 1 bit. Carry/terminal count, combinational from the state and `d`.

## Operation
- Reset:
  - While `reset`=1 at a rising edge, the next state is `q0`=0 and `q1`=0.
  - `reset` has priority over `d`.
  - `c`=0 whenever the count is not 99; after reset the count is 00, so `c`=0.
- Enable:
  - `d`=1 at an edge with no reset: the count advances by exactly 1.
  - `d`=0: the count holds.
- Units digit: `q0` goes 0→1→…→9→0. When it wraps from 9 to 0, `q1` increments in the same edge.
- Tens digit:
  - `q1` changes only on a units wrap with `d`=1.
  - When `q1`=9 and `q0`=9, the next enabled edge gives 00 (wrap-around).
- Carry: `c` = (`q1`==9 && `q0`==9 && `d`==1).
  - Asserted during the cycle whose rising edge performs the 99→00 wrap.
  - Deasserted at all other times.
- Illegal codes (10–15 in either digit) are unreachable from reset. If forced, the next enabled edge loads that digit with 0; the tens digit does not increment.

## Timing
- Latency: one clock from `d` sampled high to the new count on `q0`/`q1`.
- `c` has zero latency: it is combinational on `d` and the registered count.
- Reset takes effect on the edge where it is sampled. The outputs read 00 starting the cycle after that edge.
- Reset mid-count (e.g. at 47): the next edge gives 00, regardless of `d`.
- `d` deasserted mid-count: the count freezes at its current value. `c`=0 while `d`=0, even at 99.
- Count value after N enabled edges from reset is N mod 100, encoded as `q1`=N/10 and `q0`=N%10.

## Configuration
- Macro `BCD_COUNTER_100_SATURATE_EN`:
  - Undefined (default): wrap-around behaviour as described above.
  - Defined: the counter saturates at 99. Further enabled edges hold 99, and `c` = (count==99), independent of `d`, as a level "full" flag.
  - Reset behaviour is identical in both builds.

## Structure
- Shared package `bcd_counter_pkg`:
  - `BCD_W`=4.
  - `BCD_MAX`=4'd9.
  - `BCD_ZERO`=4'd0.
  - Typedef for a 4-bit BCD digit.
- Sub-module `bcd_digit`, instantiated twice:
  - Ports: `clk`, `reset`, `en`, `q`[3:0], `tc`.
  - `tc` = (`q`==9) & `en`.
  - Counts mod 10 with enable; saturate mode passed as a port or parameter.
- Chaining inside the top:
  - `units.en` = `d`.
  - `tens.en` = `units.tc`.
  - `c` = `tens.tc`.

## Test plan
- Reset then idle: `reset`=1 for 1 cycle, `d`=0 for 7 cycles → `q1`:`q0` = 0:0 throughout, `c`=0.
- Count 18 edges: `d`=1 for 18 cycles after reset → counts pass through 0:9, 1:0 and end at 1:8; `c` never asserts.
- Hold: after 1:8, `d`=0 for 7 cycles → stays at 1:8, `c`=0.
- Full wrap: 99 enabled edges → 9:9 with `c`=1 while `d`=1 and `c`=0 while `d`=0; the 100th edge → 0:0 and `c`=0.
- Reset mid-count: at 4:7 with `d`=1, assert `reset` for one edge → 0:0 on the next cycle, then counting resumes 0:1.
- Saturate build (`BCD_COUNTER_100_SATURATE_EN` defined): 105 enabled edges → holds at 9:9 with `c`=1; reset → 0:0, `c`=0.
